// File: rtl/fpu_half_mul.sv
// fpu_half_mul: pipelined binary16 multiplier with round-to-nearest-even.
// Stage A unpacks the operands, multiplies the mantissas and classifies specials.
// Stage B normalizes the product and denormalizes tiny results.
// Stage C rounds, packs and raises the exception flags.
// An operand pair captured on edge N appears on the outputs after edge N+LATENCY.
module fpu_half_mul #(
    parameter int LATENCY = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] result,
    output logic [4:0]  flags
);

    localparam logic [15:0] QNAN = 16'h7E00;

    // ---------------------------------------------------------------
    // Stage A: unpack, multiply, classify
    // ---------------------------------------------------------------
    logic              w_a_zero, w_b_zero;
    logic              w_a_inf, w_b_inf;
    logic              w_a_nan, w_b_nan;
    logic              w_a_snan, w_b_snan;
    logic [10:0]       w_a_mant, w_b_mant;
    logic signed [7:0] w_a_exp, w_b_exp;
    logic signed [7:0] w_esum;
    logic [21:0]       w_prod;
    logic              w_sign;
    logic              w_spec;
    logic [15:0]       w_spec_res;
    logic [4:0]        w_spec_flags;

    assign w_a_zero = (a[14:0] == 15'd0);
    assign w_b_zero = (b[14:0] == 15'd0);
    assign w_a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    assign w_b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    assign w_a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    assign w_b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    assign w_a_snan = w_a_nan && !a[9];
    assign w_b_snan = w_b_nan && !b[9];

    // Subnormals carry a zero hidden bit and share exponent field 1.
    assign w_a_mant = {(a[14:10] != 5'd0), a[9:0]};
    assign w_b_mant = {(b[14:10] != 5'd0), b[9:0]};
    assign w_a_exp  = (a[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, a[14:10]});
    assign w_b_exp  = (b[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, b[14:10]});
    // Unbiased exponent sum: (ea - 15) + (eb - 15).
    assign w_esum   = w_a_exp + w_b_exp - 8'sd30;
    assign w_prod   = 22'(w_a_mant) * 22'(w_b_mant);
    assign w_sign   = a[15] ^ b[15];

    // Special-case classification in priority order.
    always_comb begin
        w_spec       = 1'b0;
        w_spec_res   = 16'h0000;
        w_spec_flags = 5'b00000;
        if (w_a_snan || w_b_snan) begin
            w_spec       = 1'b1;
            w_spec_res   = QNAN;
            w_spec_flags = 5'b10000;
        end else if (w_a_nan || w_b_nan) begin
            w_spec       = 1'b1;
            w_spec_res   = QNAN;
        end else if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
            w_spec       = 1'b1;
            w_spec_res   = QNAN;
            w_spec_flags = 5'b10000;
        end else if (w_a_inf || w_b_inf) begin
            w_spec       = 1'b1;
            w_spec_res   = {w_sign, 15'h7C00};
        end else if (w_a_zero || w_b_zero) begin
            w_spec       = 1'b1;
            w_spec_res   = {w_sign, 15'h0000};
        end
    end

    logic [LATENCY-1:0] r_vld;
    logic               r_a_sign;
    logic [21:0]        r_a_prod;
    logic signed [7:0]  r_a_esum;
    logic               r_a_spec;
    logic [15:0]        r_a_spec_res;
    logic [4:0]         r_a_spec_flags;

    // Valid shift register; reset drops every in-flight operation.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], in_valid};
        end
    end

    // Stage A register: product, exponent sum and special-case result.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_a_sign       <= 1'b0;
            r_a_prod       <= 22'd0;
            r_a_esum       <= 8'sd0;
            r_a_spec       <= 1'b0;
            r_a_spec_res   <= 16'h0000;
            r_a_spec_flags <= 5'b00000;
        end else if (in_valid) begin
            r_a_sign       <= w_sign;
            r_a_prod       <= w_prod;
            r_a_esum       <= w_esum;
            r_a_spec       <= w_spec;
            r_a_spec_res   <= w_spec_res;
            r_a_spec_flags <= w_spec_flags;
        end
    end

    // ---------------------------------------------------------------
    // Stage B: normalize and denormalize
    // ---------------------------------------------------------------
    logic [4:0]        w_lzc;
    logic [21:0]       w_norm;
    logic signed [7:0] w_exp_b;
    logic signed [7:0] w_sh_full;
    logic              w_tiny;
    logic [5:0]        w_sh;
    logic [45:0]       w_wide;
    logic [21:0]       w_den;
    logic              w_lost;
    logic [5:0]        w_exp_adj;

    // Leading-zero count of the 22-bit product (product is nonzero unless special).
    always_comb begin
        logic found;
        found = 1'b0;
        w_lzc = 5'd0;
        for (int i = 21; i >= 0; i--) begin
            if (!found && r_a_prod[i]) begin
                w_lzc = 5'(21 - i);
                found = 1'b1;
            end
        end
    end

    assign w_norm    = r_a_prod << w_lzc;
    // Biased exponent of the normalized value 1.f: esum + 1 - lzc + 15.
    assign w_exp_b   = r_a_esum + 8'sd16 - $signed({3'b000, w_lzc});
    assign w_tiny    = (w_exp_b < 8'sd1);
    assign w_sh_full = 8'sd1 - w_exp_b;
    // Shifts past 24 only ever feed sticky, so clamp there.
    assign w_sh      = !w_tiny              ? 6'd0 :
                       (w_sh_full > 8'sd24) ? 6'd24 : 6'(w_sh_full);
    assign w_wide    = {w_norm, 24'd0} >> w_sh;
    assign w_den     = w_wide[45:24];
    assign w_lost    = |w_wide[23:0];
    // Exponent field minus one; the hidden bit is added back during packing.
    assign w_exp_adj = w_tiny ? 6'd0 : 6'(w_exp_b - 8'sd1);

    logic        r_b_sign;
    logic [10:0] r_b_mant;
    logic        r_b_g;
    logic        r_b_r;
    logic        r_b_s;
    logic [5:0]  r_b_exp_adj;
    logic        r_b_tiny;
    logic        r_b_spec;
    logic [15:0] r_b_spec_res;
    logic [4:0]  r_b_spec_flags;

    // Stage B register: aligned mantissa with guard/round/sticky.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_b_sign       <= 1'b0;
            r_b_mant       <= 11'd0;
            r_b_g          <= 1'b0;
            r_b_r          <= 1'b0;
            r_b_s          <= 1'b0;
            r_b_exp_adj    <= 6'd0;
            r_b_tiny       <= 1'b0;
            r_b_spec       <= 1'b0;
            r_b_spec_res   <= 16'h0000;
            r_b_spec_flags <= 5'b00000;
        end else if (r_vld[0]) begin
            r_b_sign       <= r_a_sign;
            r_b_mant       <= w_den[21:11];
            r_b_g          <= w_den[10];
            r_b_r          <= w_den[9];
            r_b_s          <= (|w_den[8:0]) | w_lost;
            r_b_exp_adj    <= w_exp_adj;
            r_b_tiny       <= w_tiny;
            r_b_spec       <= r_a_spec;
            r_b_spec_res   <= r_a_spec_res;
            r_b_spec_flags <= r_a_spec_flags;
        end
    end

    // ---------------------------------------------------------------
    // Stage C: round to nearest even, pack, flags
    // ---------------------------------------------------------------
    logic        w_inc;
    logic        w_inexact;
    logic [11:0] w_m12;
    logic [15:0] w_mag;
    logic [15:0] w_res;
    logic [4:0]  w_flg;

    assign w_inc     = r_b_g & (r_b_r | r_b_s | r_b_mant[0]);
    assign w_inexact = r_b_g | r_b_r | r_b_s;
    assign w_m12     = {1'b0, r_b_mant} + {11'd0, w_inc};
    // Adding the mantissa (hidden bit included) lets a rounding carry bump the
    // exponent, and lets a subnormal that rounds up become the smallest normal.
    assign w_mag     = {r_b_exp_adj, 10'd0} + {4'd0, w_m12};

    // Final result selection: special, overflow, or the rounded value.
    always_comb begin
        w_res = {r_b_sign, w_mag[14:0]};
        w_flg = {3'b000, r_b_tiny & w_inexact, w_inexact};
        if (r_b_spec) begin
            w_res = r_b_spec_res;
            w_flg = r_b_spec_flags;
        end else if (w_mag >= 16'h7C00) begin
            w_res = {r_b_sign, 15'h7C00};
            w_flg = 5'b00101;
        end
    end

    // Output register; holds the last result while no new one arrives.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_valid <= 1'b0;
            result    <= 16'h0000;
            flags     <= 5'b00000;
        end else begin
            out_valid <= r_vld[LATENCY-1];
            if (r_vld[LATENCY-1]) begin
                result <= w_res;
                flags  <= w_flg;
            end
        end
    end

endmodule

// File: tb/tb_fpu_half_mul.sv
// Directed-vector bench for fpu_half_mul with hand-computed expectations.
module tb_fpu_half_mul;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    fpu_half_mul #(.LATENCY(2)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .result   (result),
        .flags    (flags)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One operand pair; outputs must stay idle for two edges and appear on the third.
    task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic [15:0] er, input logic [4:0] ef);
        @(negedge wb_clk_i);
        a = va; b = vb; in_valid = 1'b1;
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        chk({tag, "_early0"}, 16'(out_valid), 16'd0);
        @(negedge wb_clk_i);
        chk({tag, "_early1"}, 16'(out_valid), 16'd0);
        @(negedge wb_clk_i);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_res"}, result, er);
        chk({tag, "_flags"}, 16'(flags), 16'(ef));
    endtask

    // Counts out_valid pulses over a window of cycles.
    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge wb_clk_i);
            if (out_valid === 1'b1) pulses++;
        end
    endtask

    logic [15:0] bb_a   [4] = '{16'h4000, 16'hC000, 16'h3E00, 16'h3C01};
    logic [15:0] bb_b   [4] = '{16'h4200, 16'h4200, 16'h3E00, 16'h3C01};
    logic [15:0] bb_res [4] = '{16'h4600, 16'hC600, 16'h4080, 16'h3C02};
    logic [4:0]  bb_flg [4] = '{5'b00000, 5'b00000, 5'b00000, 5'b00001};

    initial begin
        int pulses;

        // Asynchronous reset before any clock edge, with in_valid pulsing.
        #3;
        a = 16'h4000; b = 16'h4200; in_valid = 1'b1;
        wb_rst_i = 1'b1;
        #1;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_res", result, 16'h0000);
        chk("rst_flags", 16'(flags), 16'd0);
        repeat (3) begin
            @(negedge wb_clk_i);
            in_valid = ~in_valid;
        end
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        wb_rst_i = 1'b0;
        count_valid(6, pulses);
        chk("rst_no_output", 16'(pulses), 16'd0);

        // Basic, sign and rounding.
        run_vec("mul_2x3",     16'h4000, 16'h4200, 16'h4600, 5'b00000);
        run_vec("mul_neg",     16'hC000, 16'h4200, 16'hC600, 5'b00000);
        run_vec("mul_1p5sq",   16'h3E00, 16'h3E00, 16'h4080, 5'b00000);
        run_vec("round_nx",    16'h3C01, 16'h3C01, 16'h3C02, 5'b00001);

        // Overflow and special operands.
        run_vec("overflow",    16'h7BFF, 16'h4000, 16'h7C00, 5'b00101);
        run_vec("zero_x_inf",  16'h0000, 16'h7C00, 16'h7E00, 5'b10000);
        run_vec("inf_x_zero",  16'h7C00, 16'h8000, 16'h7E00, 5'b10000);
        run_vec("inf_x_neg",   16'h7C00, 16'hC000, 16'hFC00, 5'b00000);
        run_vec("snan",        16'h7D00, 16'h3C00, 16'h7E00, 5'b10000);
        run_vec("qnan",        16'h3C00, 16'hFE01, 16'h7E00, 5'b00000);
        run_vec("neg_zero",    16'h8000, 16'h3C00, 16'h8000, 5'b00000);

        // Subnormals and underflow.
        run_vec("sub_tie0",    16'h0001, 16'h3800, 16'h0000, 5'b00011);
        run_vec("sub_exact",   16'h0001, 16'h3C00, 16'h0001, 5'b00000);
        run_vec("sub_to_norm", 16'h0200, 16'h4000, 16'h0400, 5'b00000);
        run_vec("sub_rne_up",  16'h0001, 16'h3E00, 16'h0002, 5'b00011);
        run_vec("sub_carry",   16'h3BFF, 16'h0400, 16'h0400, 5'b00011);

        // Back-to-back: four pairs on consecutive cycles.
        for (int j = 0; j < 8; j++) begin
            @(negedge wb_clk_i);
            if (j >= 3 && j < 7) begin
                chk($sformatf("b2b%0d_valid", j - 3), 16'(out_valid), 16'd1);
                chk($sformatf("b2b%0d_res", j - 3), result, bb_res[j - 3]);
                chk($sformatf("b2b%0d_flags", j - 3), 16'(flags), 16'(bb_flg[j - 3]));
            end
            if (j == 7) chk("b2b_end", 16'(out_valid), 16'd0);
            if (j < 4) begin
                a = bb_a[j]; b = bb_b[j]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Asynchronous reset while a result is being presented.
        @(negedge wb_clk_i);
        a = 16'h3E00; b = 16'h3E00; in_valid = 1'b1;
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        chk("pre_rst_valid", 16'(out_valid), 16'd1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 16'(out_valid), 16'd0);
        chk("async_rst_res", result, 16'h0000);
        chk("async_rst_flags", 16'(flags), 16'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        // Reset one cycle after in_valid: the operation must vanish.
        run_vec("pre_mid", 16'h4000, 16'h4200, 16'h4600, 5'b00000);
        @(negedge wb_clk_i);
        a = 16'h3C01; b = 16'h3C01; in_valid = 1'b1;
        @(negedge wb_clk_i);
        in_valid = 1'b0;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        count_valid(6, pulses);
        chk("mid_rst_no_output", 16'(pulses), 16'd0);
        chk("mid_rst_res", result, 16'h0000);

        // Pipeline works again after reset.
        run_vec("post_rst", 16'hC000, 16'h4200, 16'hC600, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fpu_half_mul.md
Name: fpu_half_mul

Overview:
- Pipelined IEEE-754 binary16 (half-precision) floating-point multiplier; the FMUL datapath of the user-project FPU inside the Caravel harness.
- Accepts one operand pair per clock and returns a correctly rounded (round-to-nearest-even) product plus exception flags two cycles later.
- A bus/GPIO wrapper sits above it and drives the 16-bit result onto user I/O pins.

Parameters:
- LATENCY, 2, register stages from in_valid to out_valid. Only 2 is supported.

Ports:
- wb_clk_i  input  1  system clock; all state updates on its rising edge
- wb_rst_i  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  16  operand A, binary16 (sign[15], exp[14:10], frac[9:0])
- b  input  16  operand B, binary16
- out_valid  output  1  result/flags valid
- result  output  16  binary16 product
- flags  output  5  {NV, DZ, OF, UF, NX}; DZ is always 0

Behaviour:
- Reset (asynchronous, wb_rst_i=1): out_valid=0, result=16'h0000, flags=5'b0, all pipeline valids cleared. Reset asserted mid-operation discards in-flight operations; nothing emerges after release.
- Throughput: fully pipelined, no stall and no backpressure. A new pair may be accepted every cycle.
- Latency: in_valid sampled at edge N gives out_valid=1 with the matching result after edge N+2.
- When out_valid=0, result and flags hold their last values.
- Stage 1:
  - Unpack each operand. Normal operands get hidden bit 1 and unbiased exponent e-15.
  - Subnormal operands (exp=0, frac≠0) get hidden bit 0 and exponent -14.
  - Sign = sa XOR sb.
  - Compute the 11x11 mantissa product (22 bits) and the exponent sum (signed, at least 7 bits).
  - Classify special cases.
- Stage 2: normalize, round, pack.
  - Normalize with a leading-zero count so the product MSB is aligned; subnormal inputs can need a left shift of up to 20.
  - If the biased exponent is ≤0, right-shift into the subnormal range. Shifted-out bits go into sticky.
  - Round-to-nearest-even using guard/round/sticky. A mantissa carry from rounding increments the exponent, which can turn a subnormal into a normal or a finite value into overflow.
- Special cases (priority order):
  - Any signaling NaN input → 16'h7E00, NV=1.
  - Otherwise any quiet NaN input → 16'h7E00, NV=0.
  - 0 × ±Inf (either order) → 16'h7E00, NV=1.
  - Inf × finite nonzero or Inf × Inf → signed Inf (7C00/FC00).
  - Zero × finite → signed zero.
- Overflow: a rounded exponent ≥31 gives a signed Inf with OF=1 and NX=1.
- Underflow:
  - UF=1 when the result is tiny (below 2^-14 before rounding) AND inexact.
  - A result that rounds to zero yields a signed zero with UF=1 and NX=1.
- NX=1 whenever any nonzero guard, round or sticky bit is discarded.
- Exact results (including exact subnormals) set no flags.
- A NaN result is always the canonical 7E00; the sign is not propagated.

Test Plan:
- Reset: assert wb_rst_i with in_valid pulsing → out_valid=0, result=0000, flags=0 immediately, without waiting for a clock edge; no output after release.
- Basic and sign:
  - a=4000, b=4200 → result 4600, flags 0, exactly 2 cycles after in_valid.
  - a=C000, b=4200 → C600.
  - a=3E00, b=3E00 → 4080.
- Rounding and back-to-back:
  - a=3C01, b=3C01 → 3C02, NX=1.
  - Issue four different pairs on consecutive cycles → four consecutive out_valid cycles with results in order.
- Overflow and specials:
  - a=7BFF, b=4000 → 7C00, OF=1, NX=1.
  - a=0000, b=7C00 → 7E00, NV=1.
  - a=7C00, b=C000 → FC00, flags 0.
  - a=7D00 (sNaN), b=3C00 → 7E00, NV=1.
- Subnormal and underflow:
  - a=0001, b=3800 → 0000, UF=1, NX=1 (tie to even).
  - a=0001, b=3C00 → 0001, flags 0.
  - a=0200, b=4000 → 0400, flags 0.
- Reset mid-pipeline: assert wb_rst_i one cycle after in_valid → no out_valid pulse ever appears for that operation.
